// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit multicycle processor: opcodes,
// control FSM states and datapath mux-select codes.
package isa_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_LW    = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SW    = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_J     = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_IN    = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_OUT   = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [STATE_W-1:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_WB_ALU = 4'd5,
        ST_MEM_RD = 4'd6,
        ST_WB_MEM = 4'd7,
        ST_MEM_WR = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_IN_WB  = 4'd11,
        ST_OUT    = 4'd12,
        ST_HALT   = 4'd13
    } state_e;

    localparam logic [SEL_W-1:0] REGDST_RT   = 2'd0;
    localparam logic [SEL_W-1:0] REGDST_RD   = 2'd1;
    localparam logic [SEL_W-1:0] REGDST_LINK = 2'd2;

    localparam logic [SEL_W-1:0] MEMTOREG_ALUOUT = 2'd0;
    localparam logic [SEL_W-1:0] MEMTOREG_MDR    = 2'd1;
    localparam logic [SEL_W-1:0] MEMTOREG_PC     = 2'd2;
    localparam logic [SEL_W-1:0] MEMTOREG_FPGAIN = 2'd3;

    localparam logic [SEL_W-1:0] ALUSRCB_B        = 2'd0;
    localparam logic [SEL_W-1:0] ALUSRCB_TWO      = 2'd1;
    localparam logic [SEL_W-1:0] ALUSRCB_SIMM     = 2'd2;
    localparam logic [SEL_W-1:0] ALUSRCB_SIMM_SH1 = 2'd3;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'd0;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'd1;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

    // Instruction sub-variant latched in DECODE so later states never look at the opcode
    localparam logic [1:0] SUB_NONE = 2'd0;
    localparam logic [1:0] SUB_ALT  = 2'd1;
    localparam logic [1:0] SUB_SW   = 2'd2;

    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             branch_ne;
        logic             i_or_d;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             reg_write;
        logic [SEL_W-1:0] reg_dst;
        logic [SEL_W-1:0] mem_to_reg;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_source;
        logic             out_write;
        logic             halted;
    } ctrl_t;

    // ALT marks R-type (vs addi), lw (vs addi), bne (vs beq), jal (vs j)
    function automatic logic [1:0] op_sub(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_BNE, OP_JAL: op_sub = SUB_ALT;
            OP_SW:                           op_sub = SUB_SW;
            default:                         op_sub = SUB_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output table: maps the control state and latched sub-variant to
// the datapath control bundle.
module control_decode
    import isa_pkg::*;
(
    input  state_e     state_i,
    input  logic [1:0] sub_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_TWO;
                ctrl_o.pc_write  = 1'b1;
            end
            ST_DECODE: ctrl_o.alu_src_b = ALUSRCB_SIMM_SH1;
            ST_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_SIMM;
            end
            ST_WB_ALU: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = MEMTOREG_ALUOUT;
                ctrl_o.reg_dst    = (sub_i == SUB_ALT) ? REGDST_RD : REGDST_RT;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = MEMTOREG_MDR;
                ctrl_o.reg_dst    = REGDST_RT;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.branch_ne     = (sub_i == SUB_ALT);
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
                if (sub_i == SUB_ALT) begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.reg_dst    = REGDST_LINK;
                    ctrl_o.mem_to_reg = MEMTOREG_PC;
                end
            end
            ST_IN_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = MEMTOREG_FPGAIN;
            end
            ST_OUT: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.out_write = 1'b1;
            end
            ST_HALT: ctrl_o.halted = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multicycle processor: sequences each
// instruction and drives datapath enables/selects as Moore outputs.
module multicycle_control
    import isa_pkg::*;
#(
    parameter int unsigned OPW             = 4,
    parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            Zero,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            BranchNE,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic [1:0]      RegDst,
    output logic [1:0]      MemToReg,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            OutWrite,
    output logic            halted,
    output logic [3:0]      state_dbg
);

    state_e                state_q, state_d;
    logic [1:0]            sub_q, sub_d;
    logic [OPCODE_W-1:0]   op;
    ctrl_t                 ctrl;
    logic                  zero_unused;

    assign op          = OPCODE_W'(opcode);
    assign zero_unused = Zero;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= ST_RST;
            sub_q   <= SUB_NONE;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
        end
    end

    // Next state; every instruction path ends back in FETCH
    always_comb begin
        state_d = ST_FETCH;
        sub_d   = sub_q;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                sub_d = op_sub(op);
                case (op)
                    OP_RTYPE:              state_d = ST_EXEC_R;
                    OP_ADDI, OP_LW, OP_SW: state_d = ST_EXEC_I;
                    OP_BEQ, OP_BNE:        state_d = ST_BRANCH;
                    OP_J, OP_JAL:          state_d = ST_JUMP;
                    OP_IN:                 state_d = ST_IN_WB;
                    OP_OUT:                state_d = ST_OUT;
                    OP_HALT:               state_d = ST_HALT;
                    default:               state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
                endcase
            end
            ST_EXEC_R: state_d = ST_WB_ALU;
            ST_EXEC_I: begin
                case (sub_q)
                    SUB_ALT: state_d = ST_MEM_RD;
                    SUB_SW:  state_d = ST_MEM_WR;
                    default: state_d = ST_WB_ALU;
                endcase
            end
            ST_MEM_RD: state_d = ST_WB_MEM;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    control_decode u_decode (
        .state_i (state_q),
        .sub_i   (sub_q),
        .ctrl_o  (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign BranchNE    = ctrl.branch_ne;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemToReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign OutWrite    = ctrl.out_write;
    assign halted      = ctrl.halted;
    assign state_dbg   = state_q;

endmodule
